fp_mult_pipe: RTL and testbench
===============================

Name: fp_mult_pipe

Overview:
Parametrised, fully pipelined IEEE-754-style floating-point multiplier with valid/ready handshakes on input and output. It succeeds the single-precision, fixed-rounding fp_mult_top. Changes from fp_mult_top:
- Exponent and fraction widths are generic.
- Rounding mode is selected per operation at run time.
- Back-pressure is supported without loss of data.

It sits between the operand-issue logic and the result writeback, and accepts one operation per cycle.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
FRAC_W, 23, stored fraction width (precision = FRAC_W+1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
a  in  1+EXP_W+FRAC_W  operand A {sign, exp, frac}
b  in  1+EXP_W+FRAC_W  operand B
rnd  in  3  rounding mode: 0 IEEE_near, 1 IEEE_zero, 2 IEEE_pinf, 3 IEEE_ninf, 4 near_up, 5 away_zero, 6/7 treated as IEEE_near
in_valid  in  1  operand set valid
in_ready  out  1  block can accept an operand set
z  out  1+EXP_W+FRAC_W  product
status  out  8  [0] zero, [1] inf, [2] nan, [3] tiny, [4] huge, [5] inexact, [7:6] always 0
out_valid  out  1  z/status valid
out_ready  in  1  consumer accepts result

Behaviour:
- Reset (asynchronous, active-high): all stage valid bits cleared; out_valid=0, z=0, status=0. in_ready=1 from the first cycle after rst deasserts. In-flight operations are discarded with no output. An input presented during reset is not accepted.
- Transfer rules:
  - Input transfer occurs on in_valid && in_ready at a rising edge.
  - Output transfer occurs on out_valid && out_ready.
  - a, b and rnd are captured at input transfer.
- Pipeline: 3 stages, S1 → S2 → S3, each with a valid bit.
  - S1: unpack, classify, sign XOR, exponent sum, full (FRAC_W+1)^2 mantissa product.
  - S2: normalise by 0 or 1 place, rebias exponent, form guard and sticky.
  - S3: round, handle overflow/underflow, pack, drive z and status.
- Latency: exactly 3 cycles from input transfer to out_valid when out_ready is held high. Throughput is 1 per cycle.
- Stalls:
  - A stage advances when the next stage is empty or is itself advancing.
  - in_ready = !v1 || S1 advancing. in_ready is combinational from out_ready through the chain.
  - While out_valid && !out_ready, z and status hold stable.
  - No data is dropped or duplicated. Capacity is 3 operations.
- Denormal inputs (exp=0) are treated as signed zero. Denormal results are never produced.
- Special operands:
  - Any NaN operand, or inf×0: z = canonical qNaN {0, all-ones exp, 1, zeros}; status nan=1.
  - inf×finite-nonzero: ±inf, inf=1.
  - 0×finite: ±0, zero=1.
  - Specials never set inexact, tiny or huge.
- Rounding uses guard bit G and sticky bit S.
  - IEEE_near: ties to even.
  - near_up: ties away from zero.
  - IEEE_zero: truncate.
  - IEEE_pinf: up for positive results when inexact.
  - IEEE_ninf: up in magnitude for negative results when inexact.
  - away_zero: up in magnitude whenever inexact.
  - inexact = G|S.
  - Rounding carry-out renormalises and increments the exponent before the overflow check.
- Overflow (rounded exponent ≥ max): huge=1, inexact=1.
  - Result is ±inf (inf=1) for IEEE_near, near_up, away_zero, for IEEE_pinf with positive sign, and for IEEE_ninf with negative sign.
  - Otherwise the result is ±max-normal.
- Underflow (exponent < 1 after rounding): tiny=1, inexact=1.
  - Result is ±min-normal for away_zero, for IEEE_pinf with positive sign, and for IEEE_ninf with negative sign.
  - Otherwise the result is ±0 with zero=1.

Optional Feature:
FP_MULT_EVENT_CNT_EN
- Defined: adds outputs cnt_nan, cnt_huge, cnt_tiny (16 bits each).
  - Each counter increments by 1 on every output transfer whose corresponding status bit is set.
  - Counters saturate at 0xFFFF and clear on rst.
- Undefined: the ports and logic do not exist. Behaviour is otherwise identical.

Test Plan:
- 0x3FC00000 × 0x40000000, rnd=0, out_ready=1 → z=0x40400000, status=0x00, out_valid exactly 3 cycles after input transfer.
- Tie case 0x3F800001 × 0x3FC00000 → rnd=0: 0x3FC00002; rnd=4: 0x3FC00002; rnd=1: 0x3FC00001. status inexact=1 (0x20) in all three.
- 0x7F000000 × 0x7F000000 → rnd=0: 0x7F800000, status 0x32; rnd=1: 0x7F7FFFFF, status 0x30. Underflow case 0x00800000 × 0x00800000, rnd=0 → 0x00000000, status 0x29.
- 0x7F800000 × 0x00000000 → 0x7FC00000, status 0x04. 0xFF800000 × 0x40000000 → 0xFF800000, status 0x02.
- Back-pressure: out_ready=0; drive 5 back-to-back operations. Required response:
  - in_ready drops after the 3rd acceptance.
  - z holds the first result.
  - On out_ready=1, all 5 results emerge in order, with no loss and no duplicates.
- Assert rst with 2 operations in flight → out_valid=0 immediately (asynchronous). Neither result ever appears after release.

Source files
------------

// File: rtl/fp_mult_pipe.sv
// ============================================================================
// Module      : fp_mult_pipe
// Description : Three-stage pipelined floating-point multiplier with generic
//               exponent/fraction widths, per-operation rounding mode and
//               lossless valid/ready back-pressure.
//               Optional event counters: define FP_MULT_EVENT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fp_mult_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [EXP_W+FRAC_W:0]   a,
    input  logic [EXP_W+FRAC_W:0]   b,
    input  logic [2:0]              rnd,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [EXP_W+FRAC_W:0]   z,
    output logic [7:0]              status,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef FP_MULT_EVENT_CNT_EN
   ,output logic [15:0]             cnt_nan,
    output logic [15:0]             cnt_huge,
    output logic [15:0]             cnt_tiny
`endif
);

    localparam int c_P   = FRAC_W + 1;
    localparam int c_EW2 = EXP_W + 2;

    localparam logic [c_EW2-1:0]  c_BIAS     = c_EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic [EXP_W-1:0]  c_EXP_MAX  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0]  c_EXP_MAXN = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [EXP_W-1:0]  c_EXP_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [FRAC_W-1:0] c_FRAC_0   = {FRAC_W{1'b0}};
    localparam logic [FRAC_W-1:0] c_FRAC_1   = {FRAC_W{1'b1}};
    localparam logic [FRAC_W-1:0] c_FRAC_Q   = {1'b1, {(FRAC_W-1){1'b0}}};

    localparam logic [2:0] c_RND_ZERO    = 3'd1;
    localparam logic [2:0] c_RND_PINF    = 3'd2;
    localparam logic [2:0] c_RND_NINF    = 3'd3;
    localparam logic [2:0] c_RND_NEAR_UP = 3'd4;
    localparam logic [2:0] c_RND_AWAY    = 3'd5;

    localparam int c_ST_ZERO    = 0;
    localparam int c_ST_INF     = 1;
    localparam int c_ST_NAN     = 2;
    localparam int c_ST_TINY    = 3;
    localparam int c_ST_HUGE    = 4;
    localparam int c_ST_INEXACT = 5;

    // ------------------------------------------------------------------
    // Handshake / stall chain
    // ------------------------------------------------------------------
    logic r1_valid, r2_valid, r3_valid;
    logic w_en1, w_en2, w_en3;

    assign w_en3     = !r3_valid || out_ready;
    assign w_en2     = !r2_valid || w_en3;
    assign w_en1     = !r1_valid || w_en2;
    assign in_ready  = w_en1;
    assign out_valid = r3_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r2_valid <= 1'b0;
            r3_valid <= 1'b0;
        end else begin
            if (w_en1) r1_valid <= in_valid;
            if (w_en2) r2_valid <= r1_valid;
            if (w_en3) r3_valid <= r2_valid;
        end
    end

    // ------------------------------------------------------------------
    // S1: unpack, classify, exponent sum, full mantissa product
    // ------------------------------------------------------------------
    logic [EXP_W-1:0]  w_ea, w_eb;
    logic [FRAC_W-1:0] w_fa, w_fb;
    logic              w_a_zero, w_a_inf, w_a_nan;
    logic              w_b_zero, w_b_inf, w_b_nan;
    logic              w_nan1, w_inf1, w_zero1;
    logic [2*c_P-1:0]  w_prod1;

    assign w_ea = a[FRAC_W +: EXP_W];
    assign w_eb = b[FRAC_W +: EXP_W];
    assign w_fa = a[FRAC_W-1:0];
    assign w_fb = b[FRAC_W-1:0];

    // Denormal operands collapse to signed zero
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == c_EXP_MAX) && (w_fa == '0);
    assign w_b_inf  = (w_eb == c_EXP_MAX) && (w_fb == '0);
    assign w_a_nan  = (w_ea == c_EXP_MAX) && (w_fa != '0);
    assign w_b_nan  = (w_eb == c_EXP_MAX) && (w_fb != '0);

    assign w_nan1  = w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero);
    assign w_inf1  = (w_a_inf || w_b_inf) && !w_nan1;
    assign w_zero1 = (w_a_zero || w_b_zero) && !w_nan1 && !w_inf1;

    assign w_prod1 = {{c_P{1'b0}}, 1'b1, w_fa} * {{c_P{1'b0}}, 1'b1, w_fb};

    logic               r1_sign, r1_nan, r1_inf, r1_zero;
    logic [EXP_W:0]     r1_exp_sum;
    logic [2*c_P-1:0]   r1_prod;
    logic [2:0]         r1_rnd;

    always_ff @(posedge clk) begin
        if (in_valid && w_en1) begin
            r1_sign    <= a[EXP_W+FRAC_W] ^ b[EXP_W+FRAC_W];
            r1_nan     <= w_nan1;
            r1_inf     <= w_inf1;
            r1_zero    <= w_zero1;
            r1_exp_sum <= {1'b0, w_ea} + {1'b0, w_eb};
            r1_prod    <= w_prod1;
            r1_rnd     <= rnd;
        end
    end

    // ------------------------------------------------------------------
    // S2: normalise by 0/1 place, rebias, guard and sticky
    // ------------------------------------------------------------------
    logic               w_hi;
    logic [c_P-1:0]     w_mant2;
    logic               w_guard2, w_sticky2;
    logic [c_EW2-1:0]   w_exp2;

    assign w_hi      = r1_prod[2*c_P-1];
    assign w_mant2   = w_hi ? r1_prod[2*c_P-1 -: c_P] : r1_prod[2*c_P-2 -: c_P];
    assign w_guard2  = w_hi ? r1_prod[c_P-1] : r1_prod[c_P-2];
    assign w_sticky2 = w_hi ? (|r1_prod[c_P-2:0]) : (|r1_prod[c_P-3:0]);
    // Two's-complement exponent; negative values mean underflow
    assign w_exp2    = {1'b0, r1_exp_sum} - c_BIAS + {{(c_EW2-1){1'b0}}, w_hi};

    logic               r2_sign, r2_nan, r2_inf, r2_zero;
    logic [c_EW2-1:0]   r2_exp;
    logic [c_P-1:0]     r2_mant;
    logic               r2_guard, r2_sticky;
    logic [2:0]         r2_rnd;

    always_ff @(posedge clk) begin
        if (r1_valid && w_en2) begin
            r2_sign   <= r1_sign;
            r2_nan    <= r1_nan;
            r2_inf    <= r1_inf;
            r2_zero   <= r1_zero;
            r2_exp    <= w_exp2;
            r2_mant   <= w_mant2;
            r2_guard  <= w_guard2;
            r2_sticky <= w_sticky2;
            r2_rnd    <= r1_rnd;
        end
    end

    // ------------------------------------------------------------------
    // S3: round, range check, pack
    // ------------------------------------------------------------------
    logic               w_inexact, w_up, w_carry;
    logic [c_P:0]       w_sum;
    logic [FRAC_W-1:0]  w_frac_r;
    logic [c_EW2-1:0]   w_exp_r;
    logic               w_ovf, w_unf, w_ovf_inf, w_unf_min;
    logic [EXP_W+FRAC_W:0] w_z;
    logic [7:0]         w_st;

    assign w_inexact = r2_guard || r2_sticky;

    always_comb begin
        w_up = 1'b0;
        case (r2_rnd)
            c_RND_ZERO:    w_up = 1'b0;
            c_RND_PINF:    w_up = w_inexact && !r2_sign;
            c_RND_NINF:    w_up = w_inexact && r2_sign;
            c_RND_NEAR_UP: w_up = r2_guard;
            c_RND_AWAY:    w_up = w_inexact;
            default:       w_up = r2_guard && (r2_sticky || r2_mant[0]);
        endcase
    end

    assign w_sum    = {1'b0, r2_mant} + {{c_P{1'b0}}, w_up};
    assign w_carry  = w_sum[c_P];
    assign w_frac_r = w_carry ? w_sum[c_P-1:1] : w_sum[c_P-2:0];
    assign w_exp_r  = r2_exp + {{(c_EW2-1){1'b0}}, w_carry};

    assign w_ovf = !w_exp_r[c_EW2-1] && (w_exp_r >= {2'b00, c_EXP_MAX});
    assign w_unf = w_exp_r[c_EW2-1] || (w_exp_r == '0);

    // Directed modes only clamp to the finite limit when rounding toward it
    assign w_ovf_inf = !((r2_rnd == c_RND_ZERO) ||
                         (r2_rnd == c_RND_PINF && r2_sign) ||
                         (r2_rnd == c_RND_NINF && !r2_sign));
    assign w_unf_min = (r2_rnd == c_RND_AWAY) ||
                       (r2_rnd == c_RND_PINF && !r2_sign) ||
                       (r2_rnd == c_RND_NINF && r2_sign);

    always_comb begin
        w_z  = {r2_sign, w_exp_r[EXP_W-1:0], w_frac_r};
        w_st = 8'h00;
        if (r2_nan) begin
            w_z = {1'b0, c_EXP_MAX, c_FRAC_Q};
            w_st[c_ST_NAN] = 1'b1;
        end else if (r2_inf) begin
            w_z = {r2_sign, c_EXP_MAX, c_FRAC_0};
            w_st[c_ST_INF] = 1'b1;
        end else if (r2_zero) begin
            w_z = {r2_sign, {EXP_W{1'b0}}, c_FRAC_0};
            w_st[c_ST_ZERO] = 1'b1;
        end else if (w_ovf) begin
            w_st[c_ST_HUGE]    = 1'b1;
            w_st[c_ST_INEXACT] = 1'b1;
            if (w_ovf_inf) begin
                w_z = {r2_sign, c_EXP_MAX, c_FRAC_0};
                w_st[c_ST_INF] = 1'b1;
            end else begin
                w_z = {r2_sign, c_EXP_MAXN, c_FRAC_1};
            end
        end else if (w_unf) begin
            w_st[c_ST_TINY]    = 1'b1;
            w_st[c_ST_INEXACT] = 1'b1;
            if (w_unf_min) begin
                w_z = {r2_sign, c_EXP_ONE, c_FRAC_0};
            end else begin
                w_z = {r2_sign, {EXP_W{1'b0}}, c_FRAC_0};
                w_st[c_ST_ZERO] = 1'b1;
            end
        end else begin
            w_st[c_ST_INEXACT] = w_inexact;
        end
    end

    logic [EXP_W+FRAC_W:0] r3_z;
    logic [7:0]            r3_status;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r3_z      <= '0;
            r3_status <= 8'h00;
        end else if (r2_valid && w_en3) begin
            r3_z      <= w_z;
            r3_status <= w_st;
        end
    end

    assign z      = r3_z;
    assign status = r3_status;

`ifdef FP_MULT_EVENT_CNT_EN
    // ------------------------------------------------------------------
    // Saturating event counters, advanced on output transfer
    // ------------------------------------------------------------------
    logic        w_out_fire;
    logic [15:0] r_cnt_nan, r_cnt_huge, r_cnt_tiny;

    assign w_out_fire = r3_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_nan  <= 16'h0000;
            r_cnt_huge <= 16'h0000;
            r_cnt_tiny <= 16'h0000;
        end else if (w_out_fire) begin
            if (r3_status[c_ST_NAN] && (r_cnt_nan != 16'hFFFF))
                r_cnt_nan <= r_cnt_nan + 16'd1;
            if (r3_status[c_ST_HUGE] && (r_cnt_huge != 16'hFFFF))
                r_cnt_huge <= r_cnt_huge + 16'd1;
            if (r3_status[c_ST_TINY] && (r_cnt_tiny != 16'hFFFF))
                r_cnt_tiny <= r_cnt_tiny + 16'd1;
        end
    end

    assign cnt_nan  = r_cnt_nan;
    assign cnt_huge = r_cnt_huge;
    assign cnt_tiny = r_cnt_tiny;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_mult_pipe.sv
// ============================================================================
// Module      : tb_fp_mult_pipe
// Description : Self-checking bench for fp_mult_pipe (single-precision build).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fp_mult_pipe;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    logic        clk;
    logic        rst;
    logic [31:0] a, b;
    logic [2:0]  rnd;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] z;
    logic [7:0]  status;
    logic        out_valid;
    logic        out_ready;
`ifdef FP_MULT_EVENT_CNT_EN
    logic [15:0] cnt_nan, cnt_huge, cnt_tiny;
`endif

    fp_mult_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .rnd       (rnd),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .z         (z),
        .status    (status),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef FP_MULT_EVENT_CNT_EN
       ,.cnt_nan   (cnt_nan),
        .cnt_huge  (cnt_huge),
        .cnt_tiny  (cnt_tiny)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_out = 0;
    bit sb_en = 1'b0;
    logic [39:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  rnd;
        logic [31:0] z;
        logic [7:0]  st;
    } vec_t;

    vec_t vecs[29];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Reference: exact integer product, then rounding by remainder comparison
    function automatic logic [39:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic [2:0] rm);
        int e;
        logic s;
        logic [7:0] ex, ey, e8;
        logic [22:0] fx, fy;
        longint unsigned prod, keep, rem, half;
        int sh;
        bit inexact, up, nanx, nany, infx, infy, zx, zy, to_big;
        ex = x[30:23]; ey = y[30:23]; fx = x[22:0]; fy = y[22:0];
        s  = x[31] ^ y[31];
        zx = (ex == 0); zy = (ey == 0);
        infx = (ex == 8'hFF) && (fx == 0); infy = (ey == 8'hFF) && (fy == 0);
        nanx = (ex == 8'hFF) && (fx != 0); nany = (ey == 8'hFF) && (fy != 0);
        if (nanx || nany || (infx && zy) || (infy && zx)) return {32'h7FC00000, 8'h04};
        if (infx || infy) return {s, 8'hFF, 23'h0, 8'h02};
        if (zx || zy) return {s, 31'h0, 8'h01};
        prod = (64'd8388608 + 64'(fx)) * (64'd8388608 + 64'(fy));
        e = int'(ex) + int'(ey) - 127;
        if (prod >= 64'h8000_0000_0000) begin sh = 24; e = e + 1; end
        else sh = 23;
        keep = prod >> sh;
        rem  = prod - (keep << sh);
        half = 64'd1 << (sh - 1);
        inexact = (rem != 0);
        case (rm)
            3'd1: up = 1'b0;
            3'd2: up = inexact && !s;
            3'd3: up = inexact && s;
            3'd4: up = (rem >= half);
            3'd5: up = inexact;
            default: up = (rem > half) || ((rem == half) && keep[0]);
        endcase
        keep = keep + 64'(up);
        if (keep == 64'd16777216) begin keep = keep >> 1; e = e + 1; end
        if (e >= 255) begin
            to_big = !((rm == 3'd1) || (rm == 3'd2 && s) || (rm == 3'd3 && !s));
            return to_big ? {s, 8'hFF, 23'h0, 8'h32} : {s, 8'hFE, 23'h7FFFFF, 8'h30};
        end
        if (e < 1) begin
            to_big = (rm == 3'd5) || (rm == 3'd2 && !s) || (rm == 3'd3 && s);
            return to_big ? {s, 8'h01, 23'h0, 8'h28} : {s, 31'h0, 8'h29};
        end
        e8 = e[7:0];
        return {s, e8, keep[22:0], 2'b00, inexact, 5'b00000};
    endfunction

    function automatic logic [31:0] gen_op();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 7);
        case (k)
            0: ;
            1: r[30:23] = 8'($urandom_range(100, 154));
            2: r[30:23] = 8'($urandom_range(200, 254));
            3: r[30:23] = 8'($urandom_range(1, 40));
            4: case ($urandom_range(0, 6))
                   0: r = 32'h00000000;
                   1: r = 32'h80000000;
                   2: r = 32'h7F800000;
                   3: r = 32'hFF800000;
                   4: r = 32'h7FC00000;
                   5: r = {r[31], 8'hFF, 22'h0, 1'b1};
                   default: r[30:23] = 8'h00;
               endcase
            default: r[30:23] = 8'($urandom_range(110, 144));
        endcase
        return r;
    endfunction

    // Samples handshakes 1 ns after the falling edge, then waits for the next one
    task automatic tick(output bit fin);
        logic [39:0] e;
        #1;
        fin = in_valid && in_ready && !rst;
        if (out_valid && out_ready && !rst) begin
            n_out++;
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_unexpected_output: got z=%h expected no output", z);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_z", z, e[39:8]);
                    check("sb_status", {24'h0, status}, {24'h0, e[7:0]});
                end
            end
        end
        if (fin && sb_en) exp_q.push_back(ref_mul(a, b, rnd));
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fin;
        int lat, idx, first_drop, seen, n0;

        vecs[0]  = '{32'h3FC00000, 32'h40000000, 3'd0, 32'h40400000, 8'h00};
        vecs[1]  = '{32'h3F800001, 32'h3FC00000, 3'd0, 32'h3FC00002, 8'h20};
        vecs[2]  = '{32'h3F800001, 32'h3FC00000, 3'd4, 32'h3FC00002, 8'h20};
        vecs[3]  = '{32'h3F800001, 32'h3FC00000, 3'd1, 32'h3FC00001, 8'h20};
        vecs[4]  = '{32'h3F800001, 32'h3FC00000, 3'd6, 32'h3FC00002, 8'h20};
        vecs[5]  = '{32'h3F800003, 32'h3FC00000, 3'd0, 32'h3FC00004, 8'h20};
        vecs[6]  = '{32'h3F800003, 32'h3FC00000, 3'd4, 32'h3FC00005, 8'h20};
        vecs[7]  = '{32'h3F800001, 32'h3F800001, 3'd5, 32'h3F800003, 8'h20};
        vecs[8]  = '{32'h3F800001, 32'h3F800001, 3'd0, 32'h3F800002, 8'h20};
        vecs[9]  = '{32'hBF800001, 32'h3F800001, 3'd2, 32'hBF800002, 8'h20};
        vecs[10] = '{32'hBF800001, 32'h3F800001, 3'd3, 32'hBF800003, 8'h20};
        vecs[11] = '{32'h7F000000, 32'h7F000000, 3'd0, 32'h7F800000, 8'h32};
        vecs[12] = '{32'h7F000000, 32'h7F000000, 3'd1, 32'h7F7FFFFF, 8'h30};
        vecs[13] = '{32'h7F000000, 32'h7F000000, 3'd2, 32'h7F800000, 8'h32};
        vecs[14] = '{32'h7F000000, 32'h7F000000, 3'd3, 32'h7F7FFFFF, 8'h30};
        vecs[15] = '{32'hFF000000, 32'h7F000000, 3'd2, 32'hFF7FFFFF, 8'h30};
        vecs[16] = '{32'h00800000, 32'h00800000, 3'd0, 32'h00000000, 8'h29};
        vecs[17] = '{32'h00800000, 32'h00800000, 3'd5, 32'h00800000, 8'h28};
        vecs[18] = '{32'h80800000, 32'h00800000, 3'd3, 32'h80800000, 8'h28};
        vecs[19] = '{32'h80800000, 32'h00800000, 3'd2, 32'h80000000, 8'h29};
        vecs[20] = '{32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 8'h29};
        vecs[21] = '{32'h00800000, 32'h3F800000, 3'd0, 32'h00800000, 8'h00};
        vecs[22] = '{32'h7F7FFFFF, 32'h3F800000, 3'd0, 32'h7F7FFFFF, 8'h00};
        vecs[23] = '{32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 8'h04};
        vecs[24] = '{32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 8'h02};
        vecs[25] = '{32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 8'h04};
        vecs[26] = '{32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, 8'h01};
        vecs[27] = '{32'h00000001, 32'hBF800000, 3'd0, 32'h80000000, 8'h01};
        vecs[28] = '{32'hFF800000, 32'hFF800000, 3'd0, 32'h7F800000, 8'h02};

        // Reset state, with an input offered during reset
        rst = 1'b1; a = 32'h3F800000; b = 32'h3F800000; rnd = 3'd0;
        in_valid = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_out_valid", {31'h0, out_valid}, 32'h0);
        check("reset_z", z, 32'h0);
        check("reset_status", {24'h0, status}, 32'h0);
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b0;
        #1;
        check("post_reset_in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick(fin);
            if (out_valid) seen++;
        end
        check("reset_input_not_accepted", 32'(seen), 32'h0);

        // Directed table: single operations with latency measured
        for (int i = 0; i < 29; i++) begin
            a = vecs[i].a; b = vecs[i].b; rnd = vecs[i].rnd;
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            check($sformatf("vec%0d_accept", i), {31'h0, in_ready}, 32'h1);
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            #1;
            while (!out_valid && lat < 8) begin
                @(negedge clk);
                lat++;
                #1;
            end
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("vec%0d_z", i), z, vecs[i].z);
            check($sformatf("vec%0d_status", i), {24'h0, status}, {24'h0, vecs[i].st});
            @(negedge clk);
        end

        // Back-pressure: five operations against a stalled consumer
        sb_en = 1'b1;
        out_ready = 1'b0;
        idx = 0; first_drop = -1; n0 = n_out;
        for (int c = 0; c < 8; c++) begin
            if (idx < 5) begin
                a = vecs[idx].a; b = vecs[idx].b; rnd = vecs[idx].rnd; in_valid = 1'b1;
            end else in_valid = 1'b0;
            tick(fin);
            if (fin) idx++;
            else if (first_drop < 0) first_drop = idx;
            if (c >= 4) begin
                #1;
                check("bp_hold_valid", {31'h0, out_valid}, 32'h1);
                check("bp_hold_z", z, vecs[0].z);
                @(negedge clk);
            end
        end
        check("bp_ready_drop_after", 32'(first_drop), 32'd3);
        out_ready = 1'b1;
        for (int c = 0; c < 30 && (idx < 5 || exp_q.size() != 0); c++) begin
            if (idx < 5) begin
                a = vecs[idx].a; b = vecs[idx].b; rnd = vecs[idx].rnd; in_valid = 1'b1;
            end else in_valid = 1'b0;
            tick(fin);
            if (fin) idx++;
        end
        in_valid = 1'b0;
        check("bp_results_count", 32'(n_out - n0), 32'd5);

        // Asynchronous reset with two operations in flight
        sb_en = 1'b0;
        out_ready = 1'b0;
        a = vecs[0].a; b = vecs[0].b; rnd = 3'd0; in_valid = 1'b1;
        tick(fin);
        a = vecs[1].a; b = vecs[1].b;
        tick(fin);
        in_valid = 1'b0;
        tick(fin);
        #1;
        check("flush_pre_valid", {31'h0, out_valid}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("flush_async_valid", {31'h0, out_valid}, 32'h0);
        check("flush_async_z", z, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick(fin);
            if (out_valid) seen++;
        end
        check("flush_no_ghost_output", 32'(seen), 32'h0);

        // Randomised traffic against the reference model
        sb_en = 1'b1;
        exp_q.delete();
        for (int c = 0; c < 2000; c++) begin
            a = gen_op(); b = gen_op(); rnd = 3'($urandom_range(0, 7));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick(fin);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick(fin);
        check("random_drain_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
